// File: rtl/sd_wb_burst_slave.sv
// Wishbone B3 registered-feedback slave for the SD controller register bank.
// Supports classic cycles, constant-address and incrementing bursts (linear
// and wrap4/8/16), byte selects and ERR/RTY termination. The register file is
// exported flat and every committed write beat raises a one-cycle strobe.
module sd_wb_burst_slave #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 7,
    parameter int                  ADR_LSB    = 4,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    input  logic                           CYC_I,
    input  logic                           STB_I,
    input  logic                           WE_I,
    input  logic [ADDR_WIDTH-1:0]          ADR_I,
    input  logic [DATA_WIDTH-1:0]          DAT_I,
    input  logic [DATA_WIDTH/8-1:0]        SEL_I,
    input  logic [2:0]                     CTI_I,
    input  logic [1:0]                     BTE_I,
    output logic [DATA_WIDTH-1:0]          DAT_O,
    output logic                           ACK_O,
    output logic                           ERR_O,
    output logic                           RTY_O,
    input  logic                           Busy_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] Regs_o,
    output logic                           WrStrobe_o,
    output logic [$clog2(NUM_REGS)-1:0]    WrIdx_o
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int SEL_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rty_q, rty_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic                    wr_stb_q, wr_stb_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;

    logic                    req_s;
    logic                    beat_s;
    logic                    out_of_range_s;
    logic [IDX_W-1:0]        idx_s;
    logic [IDX_W-1:0]        wrap_mask_s;
    logic [IDX_W-1:0]        ptr_nxt_s;
    logic                    unused_adr_s;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [SEL_W-1:0]      sel_v
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel_v[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign req_s          = CYC_I & STB_I;
    assign beat_s         = ack_q & CYC_I & STB_I;
    assign idx_s          = ADR_I[ADR_LSB +: IDX_W];
    assign out_of_range_s = (ADR_I >> (ADR_LSB + IDX_W)) != {ADDR_WIDTH{1'b0}};
    // Byte-offset bits below the register stride carry no information here.
    assign unused_adr_s   = ^ADR_I[ADR_LSB-1:0];

    // Next burst pointer: hold for constant bursts, increment within the wrap window otherwise.
    always_comb begin
        wrap_mask_s = {IDX_W{1'b1}};
        ptr_nxt_s   = ptr_q;
        if (CTI_I == 3'b010) begin
            case (BTE_I)
                2'b01:   wrap_mask_s = IDX_W'(5'd3);
                2'b10:   wrap_mask_s = IDX_W'(5'd7);
                2'b11:   wrap_mask_s = IDX_W'(5'd15);
                default: wrap_mask_s = {IDX_W{1'b1}};
            endcase
            ptr_nxt_s = (ptr_q & ~wrap_mask_s) | ((ptr_q + IDX_W'(1'b1)) & wrap_mask_s);
        end else begin
            ptr_nxt_s = ptr_q;
        end
    end

    // Bus FSM: decode new cycles, run bursts and commit write beats.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        err_d    = 1'b0;
        rty_d    = 1'b0;
        ptr_d    = ptr_q;
        dat_d    = dat_q;
        regs_d   = regs_q;
        wr_stb_d = 1'b0;
        wr_idx_d = wr_idx_q;
        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    if (Busy_i) begin
                        rty_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (out_of_range_s || (WE_I && RO_MASK[idx_s])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        ack_d   = 1'b1;
                        ptr_d   = idx_s;
                        dat_d   = regs_q[idx_s];
                        if ((CTI_I == 3'b001) || (CTI_I == 3'b010)) begin
                            state_d = ST_BURST;
                        end else begin
                            state_d = ST_CLASSIC;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLASSIC: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
                if (beat_s && WE_I) begin
                    regs_d[ptr_q] = merge_bytes(regs_q[ptr_q], DAT_I, SEL_I);
                    wr_stb_d      = 1'b1;
                    wr_idx_d      = ptr_q;
                end else begin
                    wr_stb_d = 1'b0;
                end
            end
            ST_BURST: begin
                if (!CYC_I) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (beat_s) begin
                    if (WE_I) begin
                        regs_d[ptr_q] = merge_bytes(regs_q[ptr_q], DAT_I, SEL_I);
                        wr_stb_d      = 1'b1;
                        wr_idx_d      = ptr_q;
                    end else begin
                        wr_stb_d = 1'b0;
                    end
                    ptr_d = ptr_nxt_s;
                    dat_d = regs_d[ptr_nxt_s];
                    if (CTI_I == 3'b111) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (WE_I && RO_MASK[ptr_nxt_s]) begin
                        ack_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ST_BURST;
                    end
                end else begin
                    // Master wait state: hold pointer, data and acknowledge.
                    state_d = ST_BURST;
                end
            end
            ST_RESP: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, response flags, read data and register file.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            ptr_q    <= {IDX_W{1'b0}};
            dat_q    <= {DATA_WIDTH{1'b0}};
            wr_stb_q <= 1'b0;
            wr_idx_q <= {IDX_W{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rty_q    <= rty_d;
            ptr_q    <= ptr_d;
            dat_q    <= dat_d;
            wr_stb_q <= wr_stb_d;
            wr_idx_q <= wr_idx_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flatten the register file for the SD core.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign Regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign DAT_O      = dat_q;
    assign ACK_O      = ack_q & CYC_I & STB_I;
    assign ERR_O      = err_q & CYC_I & STB_I;
    assign RTY_O      = rty_q & CYC_I & STB_I;
    assign WrStrobe_o = wr_stb_q;
    assign WrIdx_o    = wr_idx_q;

endmodule

// File: tb/tb_sd_wb_burst_slave.sv
// Directed bench for sd_wb_burst_slave. Instance A uses the default 8-register
// map; instance B has 4 registers with register 1 read-only, for range and
// read-only error cases. Both share the bus inputs.
module tb_sd_wb_burst_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [6:0]  adr = 7'd0;
    logic [31:0] dat_i = 32'd0;
    logic [3:0]  sel = 4'h0;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;
    logic        busy = 1'b0;

    logic [31:0]  dat_a, dat_b;
    logic         ack_a, err_a, rty_a, ack_b, err_b, rty_b;
    logic [255:0] regs_a;
    logic [127:0] regs_b;
    logic         wstb_a, wstb_b;
    logic [2:0]   widx_a;
    logic [1:0]   widx_b;

    int n_checks = 0;
    int n_fail   = 0;

    sd_wb_burst_slave dut_a (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat_i), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte),
        .DAT_O(dat_a), .ACK_O(ack_a), .ERR_O(err_a), .RTY_O(rty_a),
        .Busy_i(busy), .Regs_o(regs_a), .WrStrobe_o(wstb_a), .WrIdx_o(widx_a)
    );

    sd_wb_burst_slave #(.NUM_REGS(4), .RO_MASK(4'b0010)) dut_b (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat_i), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte),
        .DAT_O(dat_b), .ACK_O(ack_b), .ERR_O(err_b), .RTY_O(rty_b),
        .Busy_i(busy), .Regs_o(regs_b), .WrStrobe_o(wstb_b), .WrIdx_o(widx_b)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_a(input int i);
        return regs_a[i*32 +: 32];
    endfunction

    function automatic logic [31:0] reg_b(input int i);
        return regs_b[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One classic cycle; reports termination in the request cycle and the response cycle.
    task automatic bus_classic(input logic on_b, input logic w, input logic [6:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output logic wait_term, output logic ack, output logic err,
                               output logic rty, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        cti = 3'b000; bte = 2'b00;
        #1;
        wait_term = on_b ? (ack_b | err_b | rty_b) : (ack_a | err_a | rty_a);
        tick();
        #1;
        ack = on_b ? ack_b : ack_a;
        err = on_b ? err_b : err_a;
        rty = on_b ? rty_b : rty_a;
        rd  = on_b ? dat_b : dat_a;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    logic        wt, ak, er, ry;
    logic [31:0] rd;
    logic [31:0] t2_dat [4];
    logic        t3_stb [6];
    logic [31:0] t3_dat [6];
    logic [31:0] t5_dat [3];
    int          stb_cnt;

    initial begin
        t2_dat = '{32'h6666_0006, 32'h7777_0007, 32'h0000_AAAA, 32'h1111_0001};
        t3_stb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        t3_dat = '{32'h6666_0006, 32'h7777_0007, 32'h4444_0004,
                   32'h4444_0004, 32'h4444_0004, 32'h5555_0005};
        t5_dat = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};

        // ---- 1: reset state, classic read and byte-masked classic write
        tick(); tick();
        rst = 1'b0;
        tick();
        check_value("rst_ack", ack_a, 0);
        check_value("rst_dat", dat_a, 0);
        check_value("rst_wstb", wstb_a, 0);
        check_value("rst_reg3", reg_a(3), 0);

        bus_classic(1'b0, 1'b0, 7'h30, 32'h0, 4'h0, wt, ak, er, ry, rd);
        check_value("t1_rd_wait", wt, 0);
        check_value("t1_rd_ack", ak, 1);
        check_value("t1_rd_dat", rd, 0);
        #1 check_value("t1_rd_ack_after", ack_a, 0);

        bus_classic(1'b0, 1'b1, 7'h20, 32'hFFFF_FFFF, 4'hF, wt, ak, er, ry, rd);
        tick();
        bus_classic(1'b0, 1'b1, 7'h20, 32'hA5A5_1234, 4'b0011, wt, ak, er, ry, rd);
        check_value("t1_wr_ack", ak, 1);
        #1;
        check_value("t1_wr_reg2", reg_a(2), 64'hFFFF_1234);
        check_value("t1_wstb", wstb_a, 1);
        check_value("t1_widx", widx_a, 2);
        tick();
        check_value("t1_wstb_off", wstb_a, 0);

        // ---- 2: linear incrementing write burst from idx 6 wrapping past the top
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h60; sel = 4'hF;
        cti = 3'b010; bte = 2'b00; dat_i = t2_dat[0];
        #1 check_value("t2_wait", ack_a, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            dat_i = t2_dat[k];
            cti = (k == 3) ? 3'b111 : 3'b010;
            #1 check_value($sformatf("t2_ack%0d", k), ack_a, 1);
            tick();
        end
        #1 check_value("t2_ack_end", ack_a, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check_value("t2_reg6", reg_a(6), t2_dat[0]);
        check_value("t2_reg7", reg_a(7), t2_dat[1]);
        check_value("t2_reg0", reg_a(0), t2_dat[2]);
        check_value("t2_reg1", reg_a(1), t2_dat[3]);
        tick();

        // ---- 3: wrap4 read burst from idx 6 with a two-cycle master wait
        bus_classic(1'b0, 1'b1, 7'h40, 32'h4444_0004, 4'hF, wt, ak, er, ry, rd);
        tick();
        bus_classic(1'b0, 1'b1, 7'h50, 32'h5555_0005, 4'hF, wt, ak, er, ry, rd);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 7'h60; cti = 3'b010; bte = 2'b01;
        tick();
        for (int k = 0; k < 6; k++) begin
            stb = t3_stb[k];
            cti = (k == 5) ? 3'b111 : 3'b010;
            #1;
            check_value($sformatf("t3_ack%0d", k), ack_a, t3_stb[k]);
            check_value($sformatf("t3_dat%0d", k), dat_a, t3_dat[k]);
            tick();
        end
        #1 check_value("t3_ack_end", ack_a, 0);
        cyc = 1'b0; stb = 1'b0;
        tick();

        // ---- 4: out of range, retry while busy, write to read-only register
        bus_classic(1'b1, 1'b1, 7'h40, 32'hDEAD_BEEF, 4'hF, wt, ak, er, ry, rd);
        check_value("t4_oor_wait", wt, 0);
        check_value("t4_oor_err", er, 1);
        check_value("t4_oor_ack", ak, 0);
        #1;
        check_value("t4_oor_err_after", err_b, 0);
        check_value("t4_oor_wstb", wstb_b, 0);
        tick();
        busy = 1'b1;
        bus_classic(1'b1, 1'b0, 7'h00, 32'h0, 4'h0, wt, ak, er, ry, rd);
        busy = 1'b0;
        check_value("t4_busy_rty", ry, 1);
        check_value("t4_busy_ack", ak, 0);
        #1 check_value("t4_busy_rty_after", rty_b, 0);
        tick();
        bus_classic(1'b1, 1'b1, 7'h10, 32'hCAFE_BABE, 4'hF, wt, ak, er, ry, rd);
        check_value("t4_ro_err", er, 1);
        check_value("t4_ro_ack", ak, 0);
        #1 check_value("t4_ro_reg1", reg_b(1), 0);
        tick();

        // ---- 5: constant-address write burst to idx 5
        stb_cnt = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h50; sel = 4'hF;
        cti = 3'b001; bte = 2'b00; dat_i = t5_dat[0];
        tick();
        for (int k = 0; k < 3; k++) begin
            dat_i = t5_dat[k];
            cti = (k == 2) ? 3'b111 : 3'b001;
            #1 if (wstb_a) stb_cnt++;
            tick();
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 if (wstb_a) stb_cnt++;
            tick();
        end
        check_value("t5_reg5", reg_a(5), 32'h0000_0033);
        check_value("t5_strobes", stb_cnt, 3);
        check_value("t5_widx", widx_a, 5);

        // ---- 6: asynchronous reset mid-burst, then CYC drop mid-burst
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 7'h20; cti = 3'b010; bte = 2'b00;
        tick();
        #1 check_value("t6_ack_pre", ack_a, 1);
        #2 rst = 1'b1;
        #1;
        check_value("t6_rst_ack", ack_a, 0);
        check_value("t6_rst_err", err_a, 0);
        check_value("t6_rst_rty", rty_a, 0);
        check_value("t6_rst_dat", dat_a, 0);
        check_value("t6_rst_reg2", reg_a(2), 0);
        check_value("t6_rst_reg5", reg_a(5), 0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h00; sel = 4'hF;
        cti = 3'b010; bte = 2'b00; dat_i = 32'h0A0A_0A0A;
        tick();
        #1 check_value("t6_beat0_ack", ack_a, 1);
        tick();
        cyc = 1'b0; dat_i = 32'h0000_BBBB;
        #1 check_value("t6_cycdrop_ack", ack_a, 0);
        tick();
        stb = 1'b0; we = 1'b0;
        check_value("t6_reg0", reg_a(0), 32'h0A0A_0A0A);
        check_value("t6_reg1", reg_a(1), 0);
        bus_classic(1'b0, 1'b0, 7'h00, 32'h0, 4'h0, wt, ak, er, ry, rd);
        check_value("t6_next_wait", wt, 0);
        check_value("t6_next_ack", ak, 1);
        check_value("t6_next_dat", rd, 32'h0A0A_0A0A);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
